// File: rtl/cnn_layer_accel_seq_gen_pkg.sv
// Shared field layout, word type and FSM states for the sequence-table generator.
package cnn_layer_accel_seq_pkg;

    localparam int SEQ_RM_BIT   = 12;
    localparam int SEQ_RST_BIT  = 11;
    localparam int SEQ_P_BIT    = 10;
    localparam int SEQ_ADDR_LSB = 0;
    localparam int SEQ_ADDR_W   = 10;

    typedef struct packed {
        logic [2:0]            rsvd;
        logic                  rm;
        logic                  rst;
        logic                  p;
        logic [SEQ_ADDR_W-1:0] addr;
    } seq_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_PAD,
        ST_DRAIN
    } seq_state_t;

    function automatic seq_word_t make_seq_word(input logic rm, input logic rst, input logic p,
                                                input logic [SEQ_ADDR_W-1:0] addr);
        logic [15:0] w;
        w = '0;
        w[SEQ_RM_BIT] = rm;
        w[SEQ_RST_BIT] = rst;
        w[SEQ_P_BIT] = p;
        w[SEQ_ADDR_LSB +: SEQ_ADDR_W] = addr;
        return seq_word_t'(w);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_seq_gen_if.sv
// Beat stream from the generator into the quad's sequence BRAM loader.
interface cnn_layer_accel_seq_gen_if #(
    parameter int C_LANES = 8
);
    logic                   config_valid;
    logic                   config_accept;
    logic [16*C_LANES-1:0]  config_data;

    modport master (output config_valid, output config_data, input config_accept);
    modport slave  (input config_valid, input config_data, output config_accept);
endinterface

// File: rtl/cnn_layer_accel_seq_gen_word_gen.sv
// Per-group address/parity state; emits one sequence word per enable, group after group.
module cnn_layer_accel_seq_word_gen
    import cnn_layer_accel_seq_pkg::*;
#(
    parameter int C_WORDS_PER_GROUP = 5,
    parameter int C_ADDR_WIDTH      = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    input  logic                    en,
    input  logic [C_ADDR_WIDTH-1:0] w1_base,
    input  logic [C_ADDR_WIDTH-1:0] hi_base,
    output seq_word_t               word,
    output logic                    last_word
);
    localparam int KW = $clog2(C_WORDS_PER_GROUP);
    localparam int AW = C_ADDR_WIDTH;

    logic [KW-1:0] k;
    logic [AW-1:0] w0_addr;
    logic [AW-1:0] w1_addr;
    logic [AW-1:0] hi_addr;
    logic          par;
    logic [AW-1:0] addr;
    logic          par_bit;

    // par is the group index LSB: word 0 carries its inverse, word 1 carries it directly
    always_comb begin
        last_word = (k == KW'(C_WORDS_PER_GROUP - 1));
        if (k == '0) begin
            addr    = w0_addr;
            par_bit = ~par;
        end else if (k == KW'(1)) begin
            addr    = w1_addr;
            par_bit = par;
        end else begin
            addr    = hi_addr + AW'(k) - AW'(2);
            par_bit = 1'b0;
        end
        word = make_seq_word(last_word, (k == '0), par_bit, SEQ_ADDR_W'(addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            w0_addr <= '0;
            w1_addr <= '0;
            hi_addr <= '0;
            par     <= 1'b0;
        end else if (init) begin
            k       <= '0;
            w0_addr <= '0;
            w1_addr <= w1_base;
            hi_addr <= hi_base;
            par     <= 1'b0;
        end else if (en) begin
            if (last_word) begin
                k       <= '0;
                w0_addr <= w0_addr + AW'(1);
                // word 1 advances by two only when entering an even group
                w1_addr <= w1_addr + (par ? AW'(2) : AW'(0));
                hi_addr <= hi_addr + AW'(1);
                par     <= ~par;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_seq_gen.sv
// Sequence-table generator: word generator, double-buffered lane packer, control FSM and beat handshake.
module cnn_layer_accel_seq_gen
    import cnn_layer_accel_seq_pkg::*;
#(
    parameter int C_WORDS_PER_GROUP = 5,
    parameter int C_LANES           = 8,
    parameter int C_NUM_BEATS       = 512,
    parameter int C_ADDR_WIDTH      = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                cfg_num_groups,
    input  logic [C_ADDR_WIDTH-1:0]    cfg_w1_base,
    input  logic [C_ADDR_WIDTH-1:0]    cfg_hi_base,
    output logic                       busy,
    output logic                       done,
    cnn_layer_accel_seq_gen_if.master  cfg_bus
);
    localparam int TOTAL_WORDS = C_NUM_BEATS * C_LANES;
    localparam int MAX_GROUPS  = TOTAL_WORDS / C_WORDS_PER_GROUP;
    localparam int WCW         = $clog2(TOTAL_WORDS + 1);
    localparam int BCW         = $clog2(C_NUM_BEATS + 1);
    localparam int LW          = (C_LANES > 1) ? $clog2(C_LANES) : 1;
    localparam int BEAT_W      = 16 * C_LANES;

    seq_state_t        state, state_nxt;
    logic [15:0]       eff_groups;
    logic [15:0]       group_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [LW-1:0]     lane_cnt;
    logic [BCW-1:0]    beat_cnt;
    logic [BEAT_W-1:0] fill_data;
    logic [BEAT_W-1:0] out_data;
    logic              fill_full;
    logic              out_valid;

    seq_word_t         gen_word;
    logic              gen_last;
    logic              gen_en;
    logic              init;
    logic [15:0]       new_word;
    logic              word_valid;
    logic              word_wr;
    logic              hshake;
    logic              xfer;
    logic              can_write;
    logic              last_lane;
    logic              last_group;
    logic              last_table_word;
    logic              last_hshake;

    cnn_layer_accel_seq_word_gen #(
        .C_WORDS_PER_GROUP (C_WORDS_PER_GROUP),
        .C_ADDR_WIDTH      (C_ADDR_WIDTH)
    ) u_word_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .en        (gen_en),
        .w1_base   (cfg_w1_base),
        .hi_base   (cfg_hi_base),
        .word      (gen_word),
        .last_word (gen_last)
    );

    // The fill register drains into the beat register whenever the beat register is free
    assign hshake          = out_valid & cfg_bus.config_accept;
    assign xfer            = fill_full & (~out_valid | cfg_bus.config_accept);
    assign can_write       = ~fill_full | xfer;
    assign last_lane       = (lane_cnt == LW'(C_LANES - 1));
    assign last_group      = (group_cnt == eff_groups - 16'd1);
    assign last_table_word = (word_cnt == WCW'(TOTAL_WORDS - 1));
    assign last_hshake     = hshake & (beat_cnt == BCW'(C_NUM_BEATS - 1));
    assign word_wr         = word_valid & can_write;

    assign busy                 = (state != ST_IDLE);
    assign cfg_bus.config_valid = out_valid;
    assign cfg_bus.config_data  = out_data;

    always_comb begin
        state_nxt  = state;
        init       = 1'b0;
        gen_en     = 1'b0;
        word_valid = 1'b0;
        new_word   = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    init      = 1'b1;
                    state_nxt = ST_GEN;
                end
            end
            ST_GEN: begin
                if (eff_groups == 16'd0) begin
                    state_nxt = ST_PAD;
                end else begin
                    word_valid = 1'b1;
                    new_word   = gen_word;
                    if (can_write) begin
                        gen_en = 1'b1;
                        if (gen_last && last_group)
                            state_nxt = last_table_word ? ST_DRAIN : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                word_valid = 1'b1;
                if (can_write && last_table_word)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_hshake)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            eff_groups <= '0;
            group_cnt  <= '0;
            word_cnt   <= '0;
            lane_cnt   <= '0;
            beat_cnt   <= '0;
            fill_full  <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_DRAIN) & last_hshake;
            if (init) begin
                eff_groups <= (cfg_num_groups > 16'(MAX_GROUPS)) ? 16'(MAX_GROUPS) : cfg_num_groups;
                group_cnt  <= '0;
                word_cnt   <= '0;
                lane_cnt   <= '0;
                beat_cnt   <= '0;
            end else begin
                if (gen_en && gen_last)
                    group_cnt <= group_cnt + 16'd1;
                if (word_wr) begin
                    word_cnt <= word_cnt + WCW'(1);
                    lane_cnt <= last_lane ? '0 : lane_cnt + LW'(1);
                end
                if (hshake)
                    beat_cnt <= beat_cnt + BCW'(1);
            end
            if (word_wr && last_lane)
                fill_full <= 1'b1;
            else if (xfer)
                fill_full <= 1'b0;
            if (xfer)
                out_valid <= 1'b1;
            else if (hshake)
                out_valid <= 1'b0;
        end
    end

    // Words shift in from the top so the first word of a beat ends up in lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_data <= '0;
            out_data  <= '0;
        end else begin
            if (word_wr)
                fill_data <= BEAT_W'({new_word, fill_data} >> 16);
            if (xfer)
                out_data <= fill_data;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_seq_gen.sv
// Scoreboard bench: expected beats come from an arithmetic model of the table rules; a monitor checks every handshake.
module tb_cnn_layer_accel_seq_gen;

    localparam int WPG   = 5;
    localparam int LANES = 8;
    localparam int NB    = 512;
    localparam int AW    = 10;
    localparam int BW    = 16 * LANES;
    localparam int TOTAL = NB * LANES;
    localparam int MAXG  = TOTAL / WPG;
    localparam logic [BW-1:0] BEAT0 = 128'h0201_0402_0801_1202_0201_0200_0002_0C00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          accept = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   cfg_num_groups = '0;
    logic [AW-1:0] cfg_w1_base = '0;
    logic [AW-1:0] cfg_hi_base = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int duty = 100;
    int hs_count = 0;
    int first_valid_cyc = -1;
    int hs0_cyc = 0;
    int hs1_cyc = 0;
    int last_hs_cyc = 0;
    int start_cyc = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got[NB];
    logic [BW-1:0] s1_got[NB];

    cnn_layer_accel_seq_gen_if #(.C_LANES(LANES)) bus();
    assign bus.config_accept = accept;

    cnn_layer_accel_seq_gen #(
        .C_WORDS_PER_GROUP (WPG),
        .C_LANES           (LANES),
        .C_NUM_BEATS       (NB),
        .C_ADDR_WIDTH      (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_num_groups (cfg_num_groups),
        .cfg_w1_base    (cfg_w1_base),
        .cfg_hi_base    (cfg_hi_base),
        .busy           (busy),
        .done           (done),
        .cfg_bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Word idx of the table: group g = idx/WPG, position k = idx%WPG
    function automatic logic [15:0] ref_word(input int idx, input int eff, input int w1b, input int hib);
        int g, k, a, p, rs, rm;
        g = idx / WPG;
        k = idx % WPG;
        if (g >= eff) return 16'h0000;
        rs = (k == 0) ? 1 : 0;
        rm = (k == WPG - 1) ? 1 : 0;
        if (k == 0) begin
            a = g;
            p = (g % 2 == 0) ? 1 : 0;
        end else if (k == 1) begin
            a = w1b + 2 * (g / 2);
            p = (g % 2 == 1) ? 1 : 0;
        end else begin
            a = hib + (k - 2) + g;
            p = 0;
        end
        a = a % (1 << AW);
        return 16'((rm << 12) | (rs << 11) | (p << 10) | a);
    endfunction

    task automatic load_model(input int ng, input int w1b, input int hib);
        int eff;
        logic [BW-1:0] beat;
        eff = (ng > MAXG) ? MAXG : ng;
        exp_q.delete();
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < LANES; l++)
                beat[16*l +: 16] = ref_word(b * LANES + l, eff, w1b, hib);
            exp_q.push_back(beat);
        end
        hs_count = 0;
        first_valid_cyc = -1;
        for (int b = 0; b < NB; b++) got[b] = '0;
    endtask

    task automatic kick(input int ng, input int w1b, input int hib);
        @(posedge clk); #1;
        cfg_num_groups = 16'(ng);
        cfg_w1_base = AW'(w1b);
        cfg_hi_base = AW'(hib);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", BW'(busy), BW'(1));
        cfg_num_groups = 16'($urandom);
        cfg_w1_base = AW'($urandom);
        cfg_hi_base = AW'($urandom);
    endtask

    task automatic run_table(input int ng, input int w1b, input int hib, input int d, input bit repulse);
        bit tmo;
        duty = d;
        load_model(ng, w1b, hib);
        kick(ng, w1b, hib);
        tmo = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (repulse && i == 60) begin
                start = 1'b1;
                cfg_num_groups = 16'd3;
                cfg_w1_base = AW'(7);
                cfg_hi_base = AW'(9);
            end
            if (i == 61) start = 1'b0;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        if (tmo) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done not seen, beats accepted %0d, required %0d", hs_count, NB);
        end else begin
            check("busy_low_with_done", BW'(busy), BW'(0));
            check("done_cycle_after_last_beat", BW'(cyc - last_hs_cyc), BW'(1));
            check("beat_count", BW'(hs_count), BW'(NB));
            check("queue_drained", BW'(exp_q.size()), BW'(0));
            @(negedge clk);
            check("done_single_pulse", BW'(done), BW'(0));
        end
    endtask

    initial begin : accept_drv
        forever begin
            @(posedge clk); #1;
            accept = (duty >= 100) || (int'($urandom_range(0, 99)) < duty);
        end
    end

    initial begin : monitor
        logic [BW-1:0] held;
        logic [BW-1:0] exp;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", BW'(bus.config_valid), BW'(1));
                    check("hold_data", bus.config_data, held);
                end
                if (bus.config_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.config_valid && accept) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_beat: got %h, expected no beat", bus.config_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check($sformatf("beat%0d", hs_count), bus.config_data, exp);
                    end
                    if (hs_count < NB) got[hs_count] = bus.config_data;
                    if (hs_count == 0) hs0_cyc = cyc;
                    if (hs_count == 1) hs1_cyc = cyc;
                    last_hs_cyc = cyc;
                    hs_count++;
                end
                stalled = bus.config_valid && !accept;
                held = bus.config_data;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time exhausted, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int diffs;
        bit tmo;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", BW'(busy), BW'(0));
        check("reset_done", BW'(done), BW'(0));
        check("reset_valid", BW'(bus.config_valid), BW'(0));
        check("reset_data", bus.config_data, BW'(0));
        rst_n = 1'b1;

        // Defaults with accept held high
        run_table(819, 2, 512, 100, 1'b0);
        check("first_valid_latency", BW'(first_valid_cyc - start_cyc), BW'(1 + (LANES + 1)));
        check("beat_interval", BW'(hs1_cyc - hs0_cyc), BW'(LANES));
        check("s1_beat0", got[0], BEAT0);
        check("s1_g2_w0", BW'(got[1][47:32]), BW'(16'h0C02));
        check("s1_g2_w1", BW'(got[1][63:48]), BW'(16'h0004));
        for (int b = 0; b < NB; b++) s1_got[b] = got[b];

        run_table(10, 2, 512, 100, 1'b0);
        check("s2_beat6_upper_zero", got[6] >> 32, BW'(0));

        run_table(819, 2, 512, 30, 1'b0);
        diffs = 0;
        for (int b = 0; b < NB; b++) if (got[b] !== s1_got[b]) diffs++;
        check("s3_matches_unstalled_run", BW'(diffs), BW'(0));

        run_table(0, 2, 512, 100, 1'b0);
        check("s4_last_beat_zero", got[NB-1], BW'(0));

        run_table(819, 2, 1022, 50, 1'b1);
        check("s5_g0_w3_wrap", BW'(got[0][63:48]), BW'(16'h03FF));
        check("s5_g0_w4_wrap", BW'(got[0][79:64]), BW'(16'h1000));

        // Abort mid-table with an asynchronous reset
        duty = 100;
        load_model(819, 2, 512);
        kick(819, 2, 512);
        tmo = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (hs_count >= 100) begin
                tmo = 1'b0;
                break;
            end
        end
        if (tmo) begin
            vectors++;
            miscompares++;
            $display("FAIL beat100_timeout: beats accepted %0d, required 100", hs_count);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", BW'(bus.config_valid), BW'(0));
        check("async_rst_data", bus.config_data, BW'(0));
        check("async_rst_busy", BW'(busy), BW'(0));
        check("async_rst_done", BW'(done), BW'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_table(819, 2, 512, 100, 1'b0);
        check("s6_beat0_after_reset", got[0], BEAT0);

        // Randomised configuration and backpressure
        run_table(int'($urandom_range(0, 900)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(20, 80)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
